// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and parameter checks for the forwarding scoreboard.
//   fwd_slot_t   : one in-flight producer slot (valid, rd, is_load, has_data, data)
//   REG_IDX_W    : register index width
//   XLEN_MAX     : widest datapath a slot can carry; slots hold data zero-extended
//   fwd_*_ok     : parameter-range checks used at elaboration
//   slot_idx_w   : index width for a slot array of a given depth
package fwd_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN_MAX  = 64;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_load;
    logic                 has_data;
    logic [XLEN_MAX-1:0]  data;
  } fwd_slot_t;

  function automatic bit fwd_depth_ok(input int depth);
    return (depth >= 32'sd1) && (depth <= 32'sd8);
  endfunction

  function automatic bit fwd_num_rd_ok(input int num_rd);
    return num_rd >= 32'sd1;
  endfunction

  function automatic bit fwd_xlen_ok(input int xlen);
    return (xlen >= 32'sd1) && (xlen <= XLEN_MAX);
  endfunction

  // A depth-1 array still needs a one-bit index.
  function automatic int slot_idx_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: Decode/EX/memory-side signals of the forwarding scoreboard.
//   master : pipeline side (drives operands, issue info, results, hold/flush)
//   slave  : scoreboard side (returns forwarded operands, fwd_en and stall)
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0][REG_IDX_W-1:0] rs_id;
  logic [NUM_RD-1:0][XLEN-1:0]      rs_data_id;
  logic                             issue_valid;
  logic [REG_IDX_W-1:0]             issue_rd;
  logic                             issue_reg_write;
  logic                             issue_is_load;
  logic [XLEN-1:0]                  ex_result;
  logic                             load_rsp_valid;
  logic [XLEN-1:0]                  load_rsp_data;
  logic                             hold;
  logic                             flush;
  logic [NUM_RD-1:0][XLEN-1:0]      fwd_rs;
  logic [NUM_RD-1:0]                fwd_en;
  logic                             stall;

  modport master (
    output rs_id, rs_data_id, issue_valid, issue_rd, issue_reg_write, issue_is_load,
           ex_result, load_rsp_valid, load_rsp_data, hold, flush,
    input  fwd_rs, fwd_en, stall
  );

  modport slave (
    input  rs_id, rs_data_id, issue_valid, issue_rd, issue_reg_write, issue_is_load,
           ex_result, load_rsp_valid, load_rsp_data, hold, flush,
    output fwd_rs, fwd_en, stall
  );
endinterface

// File: rtl/fwd_scoreboard_chk.sv
// fwd_scoreboard_chk: simulation checks for the forwarding scoreboard.
//   i_rsp_valid   : load response presented
//   i_rsp_pending : some slot is waiting for load data
// A response with nothing pending is ignored by the scoreboard and flagged here.
module fwd_scoreboard_chk (
  input logic clk,
  input logic rst_n,
  input logic i_rsp_valid,
  input logic i_rsp_pending
);
  // Flag load responses that have no waiting load to fill.
  always_ff @(posedge clk) begin
    if (rst_n && i_rsp_valid) begin
      assert (i_rsp_pending)
        else $warning("fwd_scoreboard: stray load response ignored");
    end
  end
endmodule

// File: rtl/fwd_scoreboard_lookup.sv
// fwd_lookup: per-read-port youngest-match selector (purely combinational).
//   i_slots      : scoreboard slots, index 0 = EX (youngest)
//   i_rs         : source register index; i_rs_data : register-file value
//   i_ex_result  : ALU result of slot 0
//   i_rsp_*      : load response being written this cycle (used when
//                  FWD_LOAD_BYPASS_EN is defined)
//   o_fwd_rs/o_fwd_en/o_stall : operand, forward flag, need-to-wait flag
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3
)(
  input  fwd_slot_t [DEPTH-1:0]      i_slots,
  input  logic [REG_IDX_W-1:0]       i_rs,
  input  logic [XLEN-1:0]            i_rs_data,
  input  logic [XLEN-1:0]            i_ex_result,
  input  logic                       i_rsp_fill,
  input  logic [slot_idx_w(DEPTH)-1:0] i_rsp_idx,
  input  logic [XLEN-1:0]            i_rsp_data,
  output logic [XLEN-1:0]            o_fwd_rs,
  output logic                       o_fwd_en,
  output logic                       o_stall
);
  localparam int IDX_W = slot_idx_w(DEPTH);

  logic [DEPTH-1:0] w_match;
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  fwd_slot_t        w_sel;
  logic             w_unused_sel;

  // Per-slot match; x0 never matches.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = i_slots[i].valid && (i_slots[i].rd == i_rs) && (i_rs != '0);
    end
  end

  // Walk oldest to youngest so the youngest match is left in w_idx.
  always_comb begin
    w_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_idx = w_match[i] ? IDX_W'(i) : w_idx;
    end
  end

  assign w_hit        = |w_match;
  assign w_sel        = i_slots[w_idx];
  assign w_unused_sel = ^w_sel;

  // Value selection for the winning slot.
  always_comb begin
    o_fwd_rs = i_rs_data;
    o_fwd_en = 1'b0;
    o_stall  = 1'b0;
    if (!w_hit) begin
      o_fwd_rs = i_rs_data;
    end else if ((w_idx == '0) && !w_sel.is_load) begin
      o_fwd_rs = i_ex_result;
      o_fwd_en = 1'b1;
    end else if (w_sel.has_data) begin
      o_fwd_rs = w_sel.data[XLEN-1:0];
      o_fwd_en = 1'b1;
`ifdef FWD_LOAD_BYPASS_EN
    end else if (i_rsp_fill && (i_rsp_idx == w_idx)) begin
      o_fwd_rs = i_rsp_data;
      o_fwd_en = 1'b1;
`endif
    end else begin
      // Youngest producer is a load whose data has not arrived yet.
      o_stall = 1'b1;
    end
  end

`ifndef FWD_LOAD_BYPASS_EN
  logic w_unused_rsp;
  assign w_unused_rsp = ^{i_rsp_fill, i_rsp_idx, i_rsp_data};
`endif

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: multi-slot forwarding and load-use scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fwd_scoreboard_if.slave (Decode operands, issue info, EX
//                result, load response, hold/flush in; fwd_rs/fwd_en/stall out)
// Optional feature macro: FWD_LOAD_BYPASS_EN (forward a load response in its
// arrival cycle instead of one cycle later).
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2
)(
  input logic              clk,
  input logic              rst_n,
  fwd_scoreboard_if.slave  bus
);
  localparam int IDX_W = slot_idx_w(DEPTH);
  localparam int TGT_W = IDX_W + 1;

  if (!fwd_depth_ok(DEPTH)) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH must be 1..8");
  end
  if (!fwd_num_rd_ok(NUM_RD)) begin : g_bad_num_rd
    $error("fwd_scoreboard: NUM_RD must be at least 1");
  end
  if (!fwd_xlen_ok(XLEN)) begin : g_bad_xlen
    $error("fwd_scoreboard: XLEN out of range");
  end

  fwd_slot_t [DEPTH-1:0] r_slots;
  fwd_slot_t [DEPTH-1:0] w_slots_nxt;
  fwd_slot_t             w_ex_done;
  fwd_slot_t             w_issue_slot;
  logic [NUM_RD-1:0]     w_port_stall;
  logic [DEPTH-1:0]      w_pend;
  logic [IDX_W-1:0]      w_rsp_idx;
  logic [TGT_W-1:0]      w_rsp_tgt;
  logic                  w_rsp_hit;
  logic                  w_rsp_fill;
  logic                  w_stall;
  logic                  w_adv;
  logic                  w_issue_ok;

  assign w_adv      = !bus.hold;
  assign w_stall    = |w_port_stall;
  assign bus.stall  = w_stall;
  assign w_issue_ok = bus.issue_valid && bus.issue_reg_write && (bus.issue_rd != '0)
                      && !w_stall && !bus.flush;

  // Oldest load still waiting for data; responses return in order.
  always_comb begin
    w_pend    = '0;
    w_rsp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend[i] = r_slots[i].valid && r_slots[i].is_load && !r_slots[i].has_data;
      w_rsp_idx = w_pend[i] ? IDX_W'(i) : w_rsp_idx;
    end
  end

  assign w_rsp_hit  = |w_pend;
  assign w_rsp_fill = bus.load_rsp_valid && w_rsp_hit;
  // The filled slot moves with the shift when both happen together.
  assign w_rsp_tgt  = TGT_W'(w_rsp_idx) + (w_adv ? TGT_W'(1) : TGT_W'(0));

  // Slot 0 as it leaves EX: non-loads capture the ALU result.
  always_comb begin
    w_ex_done          = r_slots[0];
    w_ex_done.has_data = r_slots[0].is_load ? r_slots[0].has_data : 1'b1;
    w_ex_done.data     = r_slots[0].is_load ? r_slots[0].data : XLEN_MAX'(bus.ex_result);
  end

  // New slot 0 contents from Decode.
  always_comb begin
    w_issue_slot          = '0;
    w_issue_slot.valid    = w_issue_ok;
    w_issue_slot.rd       = bus.issue_rd;
    w_issue_slot.is_load  = bus.issue_is_load;
    w_issue_slot.has_data = 1'b0;
  end

  // Shift on advance, then apply any load response to its post-shift slot.
  always_comb begin
    w_slots_nxt = r_slots;
    if (w_adv) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        w_slots_nxt[i] = (i == 1) ? w_ex_done : r_slots[i-1];
      end
      w_slots_nxt[0] = w_issue_slot;
    end else begin
      w_slots_nxt = r_slots;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_slots_nxt[i].has_data = (w_rsp_fill && (w_rsp_tgt == TGT_W'(i)))
                                ? 1'b1 : w_slots_nxt[i].has_data;
      w_slots_nxt[i].data     = (w_rsp_fill && (w_rsp_tgt == TGT_W'(i)))
                                ? XLEN_MAX'(bus.load_rsp_data) : w_slots_nxt[i].data;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots <= '0;
    end else begin
      r_slots <= w_slots_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_lookup #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lookup (
      .i_slots     (r_slots),
      .i_rs        (bus.rs_id[p]),
      .i_rs_data   (bus.rs_data_id[p]),
      .i_ex_result (bus.ex_result),
      .i_rsp_fill  (w_rsp_fill),
      .i_rsp_idx   (w_rsp_idx),
      .i_rsp_data  (bus.load_rsp_data),
      .o_fwd_rs    (bus.fwd_rs[p]),
      .o_fwd_en    (bus.fwd_en[p]),
      .o_stall     (w_port_stall[p])
    );
  end

  fwd_scoreboard_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rsp_valid   (bus.load_rsp_valid),
    .i_rsp_pending (w_rsp_hit)
  );

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, NUM_RD=2, XLEN=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_fwd_scoreboard;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 3;
  localparam int NUM_RD = 2;
  localparam logic [31:0] RF0 = 32'h0F0F_0F0F;
  localparam logic [31:0] RF1 = 32'h1234_5678;
`ifdef FWD_LOAD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt;
  logic exp_stall;

  fwd_scoreboard_if #(.XLEN(XLEN), .NUM_RD(NUM_RD)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs_id           = '0;
    bus.rs_data_id[0]   = RF0;
    bus.rs_data_id[1]   = RF1;
    bus.issue_valid     = 1'b0;
    bus.issue_rd        = 5'd0;
    bus.issue_reg_write = 1'b0;
    bus.issue_is_load   = 1'b0;
    bus.ex_result       = 32'h0;
    bus.load_rsp_valid  = 1'b0;
    bus.load_rsp_data   = 32'h0;
    bus.hold            = 1'b0;
    bus.flush           = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic is_load);
    bus.issue_valid     = 1'b1;
    bus.issue_rd        = rd;
    bus.issue_reg_write = 1'b1;
    bus.issue_is_load   = is_load;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle();
    bus.rs_id[0] = 5'd5;
    bus.rs_id[1] = 5'd7;
    #2;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_fwd_en", 32'(bus.fwd_en), 32'd0);
    chk("rst_rs0", bus.fwd_rs[0], RF0);
    chk("rst_rs1", bus.fwd_rs[1], RF1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // ALU chain on x5
    idle(); issue(5'd5, 1'b0); tick();
    idle(); bus.issue_valid = 1'b1; bus.rs_id[0] = 5'd5; bus.rs_id[1] = 5'd6;
    bus.ex_result = 32'h0000_0105; #1;
    chk("alu_ex_en0", 32'(bus.fwd_en[0]), 32'd1);
    chk("alu_ex_rs0", bus.fwd_rs[0], 32'h0000_0105);
    chk("alu_ex_stall", 32'(bus.stall), 32'd0);
    chk("alu_ex_en1", 32'(bus.fwd_en[1]), 32'd0);
    chk("alu_ex_rs1", bus.fwd_rs[1], RF1);
    tick();
    idle(); bus.rs_id[0] = 5'd5; bus.ex_result = 32'h0000_0999; #1;
    chk("alu_s1_en0", 32'(bus.fwd_en[0]), 32'd1);
    chk("alu_s1_rs0", bus.fwd_rs[0], 32'h0000_0105);
    tick();
    idle(); bus.rs_id[0] = 5'd5; #1;
    chk("alu_s2_en0", 32'(bus.fwd_en[0]), 32'd1);
    chk("alu_s2_rs0", bus.fwd_rs[0], 32'h0000_0105);
    tick();
    idle(); bus.rs_id[0] = 5'd5; #1;
    chk("alu_gone_en0", 32'(bus.fwd_en[0]), 32'd0);
    chk("alu_gone_rs0", bus.fwd_rs[0], RF0);

    // Same rd in slots 0 and 2: youngest wins
    idle(); issue(5'd3, 1'b0); tick();
    idle(); issue(5'd9, 1'b0); bus.ex_result = 32'h11; tick();
    idle(); issue(5'd3, 1'b0); bus.ex_result = 32'h77; tick();
    idle(); bus.ex_result = 32'h22; bus.rs_id[0] = 5'd3; bus.rs_id[1] = 5'd9; #1;
    chk("dup_rs0", bus.fwd_rs[0], 32'h22);
    chk("dup_en0", 32'(bus.fwd_en[0]), 32'd1);
    chk("dup_rs1", bus.fwd_rs[1], 32'h77);
    tick();

    // x0 is never forwarded
    idle(); issue(5'd0, 1'b0); bus.ex_result = 32'h33; tick();
    idle(); bus.ex_result = 32'h44; #1;
    chk("x0_fwd_en", 32'(bus.fwd_en), 32'd0);
    chk("x0_rs0", bus.fwd_rs[0], RF0);
    tick();

    // Flushed issue must not be tracked
    idle(); issue(5'd8, 1'b0); bus.flush = 1'b1; tick();
    idle(); bus.rs_id[0] = 5'd8; bus.ex_result = 32'h55; #1;
    chk("flush_en0", 32'(bus.fwd_en[0]), 32'd0);
    chk("flush_rs0", bus.fwd_rs[0], RF0);
    idle(); repeat (3) tick();

    // Load-use on x7: response arrives while the load sits in slot 1
    stall_cnt = 0;
    idle(); issue(5'd7, 1'b1); tick();
    idle(); issue(5'd10, 1'b0); bus.rs_id[0] = 5'd7; #1;
    stall_cnt += int'(bus.stall);
    chk("lu_stall_c1", 32'(bus.stall), 32'd1);
    chk("lu_en_c1", 32'(bus.fwd_en[0]), 32'd0);
    tick();
    idle(); issue(5'd10, 1'b0); bus.rs_id[0] = 5'd7;
    bus.load_rsp_valid = 1'b1; bus.load_rsp_data = 32'hDEAD_BEEF; #1;
    stall_cnt += int'(bus.stall);
    chk("lu_stall_rsp", 32'(bus.stall), 32'(!BYP));
    tick();
    idle(); issue(5'd10, 1'b0); bus.rs_id[0] = 5'd7; #1;
    stall_cnt += int'(bus.stall);
    chk("lu_stall_after", 32'(bus.stall), 32'd0);
    chk("lu_en_after", 32'(bus.fwd_en[0]), 32'd1);
    chk("lu_rs_after", bus.fwd_rs[0], 32'hDEAD_BEEF);
    chk("lu_stall_cycles", 32'(stall_cnt), BYP ? 32'd1 : 32'd2);
    tick();
    idle(); repeat (3) tick();

    // Hold for 5 cycles with a pending load; response mid-hold
    idle(); issue(5'd12, 1'b1); tick();
    for (int h = 0; h < 5; h++) begin
      idle(); issue(5'd13, 1'b0); bus.rs_id[0] = 5'd12; bus.hold = 1'b1;
      bus.load_rsp_valid = (h == 2); bus.load_rsp_data = 32'hCAFE_0012; #1;
      exp_stall = (h < 2) || ((h == 2) && !BYP);
      chk($sformatf("hold_stall_%0d", h), 32'(bus.stall), 32'(exp_stall));
      chk($sformatf("hold_en_%0d", h), 32'(bus.fwd_en[0]), 32'(!exp_stall));
      chk($sformatf("hold_rs_%0d", h), bus.fwd_rs[0], exp_stall ? RF0 : 32'hCAFE_0012);
      tick();
    end
    idle(); issue(5'd13, 1'b0); bus.rs_id[0] = 5'd12; #1;
    chk("hold_release_en", 32'(bus.fwd_en[0]), 32'd1);
    chk("hold_release_rs", bus.fwd_rs[0], 32'hCAFE_0012);
    tick();
    idle(); bus.rs_id[0] = 5'd12; tick();
    idle(); bus.rs_id[0] = 5'd12; #1;
    chk("hold_slot2_en", 32'(bus.fwd_en[0]), 32'd1);
    tick();
    idle(); bus.rs_id[0] = 5'd12; #1;
    chk("hold_retired_en", 32'(bus.fwd_en[0]), 32'd0);
    tick();

    // Reset while a load is pending, then a stray response
    idle(); issue(5'd14, 1'b1); tick();
    idle(); bus.rs_id[0] = 5'd14; #1;
    chk("rstmid_pre_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0; #1;
    chk("rstmid_stall", 32'(bus.stall), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    idle(); bus.rs_id[0] = 5'd14;
    bus.load_rsp_valid = 1'b1; bus.load_rsp_data = 32'h5555_AAAA; #1;
    chk("stray_stall", 32'(bus.stall), 32'd0);
    chk("stray_en0", 32'(bus.fwd_en[0]), 32'd0);
    chk("stray_rs0", bus.fwd_rs[0], RF0);
    tick();
    idle(); bus.rs_id[0] = 5'd14; #1;
    chk("stray_after_en0", 32'(bus.fwd_en[0]), 32'd0);
    chk("stray_after_stall", 32'(bus.stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised multi-slot forwarding and load-use scoreboard for the RV32I pipeline, operating between Decode and the later stages. It records every in-flight register-writing instruction from EX onward and forwards the youngest matching value to any number of Decode read ports. It also tracks variable-latency load results and raises a stall only while a needed value is still outstanding. It supersedes the single-source EX→ID forwarder, which handled one producer and stalled on every load-use.

## Interface
Parameters:
- XLEN, 32, datapath width.
- DEPTH, 3, in-flight producer slots, EX plus older stages; legal range 1..8.
- NUM_RD, 2, Decode read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_id  in  NUM_RD×5  Decode source register indices.
- rs_data_id  in  NUM_RD×XLEN  register-file values.
- issue_valid  in  1  Decode holds a real instruction.
- issue_rd  in  5  its destination register.
- issue_reg_write  in  1  it writes rd.
- issue_is_load  in  1  it is a load.
- ex_result  in  XLEN  ALU result of the instruction in slot 0.
- load_rsp_valid  in  1  load data returns this cycle.
- load_rsp_data  in  XLEN  returned load data.
- hold  in  1  external freeze (e.g. memory wait); no slot shifts.
- flush  in  1  Decode instruction is wrong-path; it must not enter slot 0.
- fwd_rs  out  NUM_RD×XLEN  operand values for Decode.
- fwd_en  out  NUM_RD  the port is using a forwarded value.
- stall  out  1  Decode must hold; a bubble enters slot 0.

## Operation
- Slot state: valid, rd, is_load, has_data, data. Slot 0 is the instruction in EX; slot DEPTH-1 is the oldest.
- Advance happens when hold is 0:
  - slot i moves to slot i+1, and slot DEPTH-1 retires.
  - slot 0 loads the issue fields if issue_valid && issue_reg_write && issue_rd≠0 && !stall && !flush.
  - otherwise slot 0 becomes invalid (a bubble).
- Data capture:
  - A non-load leaving slot 0 captures ex_result and sets has_data.
  - A load keeps has_data=0 until its response arrives.
- Load responses complete in order. A response fills the oldest valid slot with is_load && !has_data, at that slot's post-shift position if an advance happens in the same cycle.
- A response with no pending load is ignored; a simulation assertion fires.
- Forward lookup, per port p:
  - Match condition: valid && rd==rs_id[p] && rs_id[p]≠0.
  - The youngest matching slot wins.
  - Matching slot 0 that is not a load: the value is ex_result.
  - Matching slot with has_data: the value is the stored data.
  - No match: fwd_rs=rs_data_id and fwd_en=0.
- stall=1 when any port's youngest match is a load without data. In that case fwd_en=0 for that port.
- While hold=1, nothing shifts, but load responses are still captured.
- Reset clears every slot valid; all other fields are don't-care.

## Timing
- Forward outputs and stall are combinational from inputs and slot state; there is no added latency.
- A load result is usable the cycle after it is captured, unless FWD_LOAD_BYPASS_EN is defined (see Configuration).
- Reset values: all slots invalid, stall=0, fwd_en=0, fwd_rs=rs_data_id.
- Reset asserted mid-operation discards pending loads. Responses arriving after reset are ignored.
- When stall and hold are both 1, hold wins and nothing moves.
- When flush and stall are both 1, a bubble enters slot 0.
- Slot DEPTH-1 is still forwarded in its final cycle, which covers the register-file write-then-read gap.

## Configuration
- FWD_LOAD_BYPASS_EN defined: a load response is forwarded combinationally to matching ports in its arrival cycle and clears that cycle's stall.
- FWD_LOAD_BYPASS_EN undefined: the response is registered first, so the stall persists for exactly one more cycle.

## Structure
- Package fwd_pkg holds:
  - fwd_slot_t struct with fields valid, rd, is_load, has_data, data.
  - REG_IDX_W=5.
  - The parameter-range checks.
- One natural sub-module, fwd_lookup: the combinational per-port youngest-match priority selector. It is instantiated NUM_RD times.

## Test plan
- ALU chain, default parameters:
  - `addi x5` issued, then an instruction reading x5 in the next cycle → fwd_en[0]=1, fwd_rs[0]=ex_result.
  - Two cycles later → the value comes from slot 1 data.
- Load-use, response 3 cycles after issue:
  - Reading x7 → stall=1 for 3 cycles with bypass, 4 without.
  - After the stall → fwd_rs=load_rsp_data (0xDEADBEEF).
- Same rd in slots 0 and 2 (x3=0x11 older, x3=0x22 younger) → port returns 0x22.
- Edge cases:
  - rs=x0 with a slot rd=x0 → fwd_en=0.
  - flush=1 during issue → a later read of that rd gets rs_data_id.
- hold=1 for 5 cycles with a pending load; response arrives mid-hold → the slot captures it, no shift occurs, and stall drops.
- rst_n pulsed low while a load is pending, then a stray load_rsp_valid → no stall, fwd_en=0, assertion fires, state stays empty.
